// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage PC select, JALR fetch hold and IF/ID register; define FETCH_PERF_CNT_EN for perf counters
module fetch_pc_ctrl #(
  parameter int size = 32,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [size-1:0] instruction,
  input  logic [size-1:0] IMM,
  input  logic            Predicted_MPC,
  input  logic            JALR,
  input  logic            ex_redirect,
  input  logic [size-1:0] ex_target,
  output logic [size-1:0] PC,
  output logic            isValid,
  output logic [size-1:0] if_pc,
  output logic [size-1:0] if_instr,
  output logic            if_valid,
  output logic            if_pred_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);
  typedef enum logic {RUN, JALR_WAIT} state_t;
  localparam logic [size-1:0] NOP = size'(32'h0000_0013);
  localparam logic [size-1:0] ALIGN = ~size'(3);
  state_t state, state_next;
  logic accept;
  logic [size-1:0] pc_next;
  assign isValid = (state == RUN) & ~ex_redirect;
  assign accept = isValid & ~stall;
  always_comb begin
    pc_next = ex_redirect ? (ex_target & ALIGN) :
              (stall || state == JALR_WAIT || (accept && JALR)) ? PC :
              (accept && Predicted_MPC) ? ((PC + IMM) & ALIGN) : PC + size'(4);
    state_next = ex_redirect ? RUN : (accept && JALR) ? JALR_WAIT : state;
  end
  always_ff @(posedge clk)
    if (!reset) state <= RUN;
    else state <= state_next;
  always_ff @(posedge clk)
    if (!reset) begin
      PC <= RESET_PC;
      if_pc <= '0;
      if_instr <= NOP;
      if_valid <= 1'b0;
      if_pred_taken <= 1'b0;
    end else begin
      PC <= pc_next;
      if (ex_redirect) begin
        if_instr <= NOP;
        if_valid <= 1'b0;
        if_pred_taken <= 1'b0;
      end else if (!stall) begin
        if_pc <= PC;
        if_instr <= isValid ? instruction : NOP;
        if_valid <= isValid;
        if_pred_taken <= isValid & Predicted_MPC & ~JALR;
      end
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(accept);
      perf_redirect_cnt <= perf_redirect_cnt + 32'(ex_redirect);
    end
`endif
endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Instruction-fetch control stage of the RV32I 5-stage pipeline: owns the program counter, selects the next PC from sequential, predicted-taken and EX-redirect sources, and holds the IF/ID pipeline register. Sits directly upstream of the static branch predictor. Drives the PC and `isValid` into it, and consumes its `Predicted_MPC`/`JALR` decisions. Fetch stalls on JALR until EX resolves the target.

## Interface
- `size`, 32: datapath/PC width.
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard-unit hold of IF and IF/ID.
- `instruction`  in  size  instruction word at `PC`, combinational imem read.
- `IMM`  in  size  sign-extended B/J immediate of `instruction`.
- `Predicted_MPC`  in  1  predictor: instruction is JAL or predicted-taken branch.
- `JALR`  in  1  predictor: instruction is JALR.
- `ex_redirect`  in  1  EX: mispredict or JALR resolved; load `ex_target`.
- `ex_target`  in  size  EX-computed correct PC.
- `PC`  out  size  current fetch address.
- `isValid`  out  1  `instruction` at `PC` is a real fetch (not a bubble).
- `if_pc`  out  size  IF/ID: PC of held instruction.
- `if_instr`  out  size  IF/ID: instruction word.
- `if_valid`  out  1  IF/ID: entry valid.
- `if_pred_taken`  out  1  IF/ID: entry was predicted taken (for EX mispredict check).

## Operation
- FSM states: RUN, JALR_WAIT.
- `isValid` = (state==RUN) & ~`ex_redirect` (combinational).
- `accept` = `isValid` & ~`stall`.
- Next PC, priority order:
  1. `ex_redirect` → {`ex_target`[size-1:2], 2'b00}; state → RUN.
  2. `stall` → hold PC and state.
  3. JALR_WAIT → hold PC.
  4. `accept` & `JALR` → hold PC; state → JALR_WAIT.
  5. `accept` & `Predicted_MPC` → PC + `IMM`.
  6. Otherwise → PC + 4.
- All PC arithmetic is modulo 2^size; wrap-around from 0xFFFF_FFFC to 0 is legal. PC[1:0] is always 0.
- IF/ID register, priority order:
  1. `ex_redirect` → flush: `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_pred_taken`=0, `if_pc` unchanged.
  2. `stall` → hold all fields.
  3. Otherwise load `if_pc`=PC, `if_instr`=`instruction`, `if_valid`=`isValid`, `if_pred_taken`=`isValid`&`Predicted_MPC`&~`JALR`.
- In JALR_WAIT, a non-stalled cycle loads a bubble (`if_valid`=0). `if_instr` is forced to NOP whenever the loaded `if_valid` is 0.

## Timing
- Reset (`reset`=0 at clock edge): PC=`RESET_PC`, state=RUN, `if_pc`=0, `if_instr`=NOP, `if_valid`=0, `if_pred_taken`=0. Reset overrides every other input.
- Fetch latency: instruction at PC appears in IF/ID one cycle after `accept`.
- Redirect latency: `ex_redirect` at edge N → PC=target after N. The first valid IF/ID entry from the target appears after N+1.
- `ex_redirect` wins over `stall`, JALR and prediction in the same cycle.
- A JALR fetched in the same cycle as `ex_redirect` is discarded; state stays RUN.
- A JALR under `stall` does not enter JALR_WAIT until the cycle it is accepted.
- `ex_redirect` while in JALR_WAIT exits to RUN. No timeout.
- Reset asserted mid-JALR_WAIT returns to RUN at `RESET_PC`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_fetch_cnt` (32) and `perf_redirect_cnt` (32).
  - `perf_fetch_cnt` increments on each cycle where IF/ID loads `if_valid`=1.
  - `perf_redirect_cnt` increments on each `ex_redirect` cycle.
  - Both counters reset to 0 and wrap at 2^32.
- `FETCH_PERF_CNT_EN` undefined: the ports and counter logic do not exist. Behaviour is otherwise identical.

## Test plan
- Reset, then 4 ADDI instructions, no stall → PC 0,4,8,12,16. `if_valid`=1 from cycle 2, with `if_pc` trailing PC by one cycle.
- JAL at 0x10 with `IMM`=0x40, `Predicted_MPC`=1 → next PC 0x50. IF/ID holds `if_pc`=0x10, `if_pred_taken`=1.
- JALR at 0x20 → PC held at 0x20 and bubbles enter IF/ID. Then `ex_redirect`=1 with `ex_target`=0x103 → PC=0x100, state RUN.
- `stall`=1 for 3 cycles at PC 0x30 → PC and IF/ID frozen. Same cycle as a `ex_redirect`=1 with target 0x80 → PC=0x80 and IF/ID flushed to NOP with `if_valid`=0.
- PC=0xFFFF_FFFC, sequential fetch → PC wraps to 0x0. `reset`=0 during JALR_WAIT → PC=`RESET_PC`, state RUN, all IF/ID outputs at reset values.
- With `FETCH_PERF_CNT_EN`: 10 valid fetches and 2 redirects → `perf_fetch_cnt`=10, `perf_redirect_cnt`=2. Both read 0 after reset.
